// File: rtl/dm_mc.sv
// dm_mc: multi-cycle word-organised data memory for the CPU load/store path.
// Byte/half/word stores via lane enables, sign/zero-extended sub-word loads,
// request/response handshake with a parameterised wait and error reporting
// for misaligned or illegal accesses.
module dm_mc #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;
  // Counter preload; unused when there is no wait phase.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // An access is illegal for size 11 or when not naturally aligned.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    logic e;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = lane[0];
      2'b10:   e = (lane != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Select the addressed lane(s) of a word and extend to 32 bits.
  function automatic logic [31:0] load_format(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> {lane, 3'b000};
    case (size)
      2'b00:   res = uns ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   res = uns ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      2'b10:   res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  logic [31:0]      mem [0:DEPTH-1];

  state_t           state_r;
  logic [3:0]       cnt_r;
  logic             we_r;
  logic [1:0]       size_r;
  logic [1:0]       lane_r;
  logic             uns_r;
  logic             err_r;
  logic [IDX_W-1:0] idx_r;

  logic             accept_s;
  logic             req_err_s;
  logic [IDX_W-1:0] req_idx_s;
  logic             mem_we_s;
  logic [3:0]       be_s;
  logic [31:0]      wlane_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [1:0]       rd_size_s;
  logic [1:0]       rd_lane_s;
  logic             rd_uns_s;
  logic             rd_we_s;
  logic             rd_err_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      rsp_word_s;

  // Request decode, lane enables and response data formatting.
  always_comb begin
    accept_s  = req_valid & req_ready & ~rst;
    req_err_s = access_err(req_size, req_addr[1:0]);
    req_idx_s = req_addr[ADDR_W-1:2];
    mem_we_s  = accept_s & req_we & ~req_err_s;

    be_s    = 4'b0000;
    wlane_s = 32'h0000_0000;
    case (req_size)
      2'b00: begin
        be_s    = 4'b0001 << req_addr[1:0];
        wlane_s = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_s    = req_addr[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b1111;
        wlane_s = req_wdata;
      end
      default: begin
        be_s    = 4'b0000;
        wlane_s = 32'h0000_0000;
      end
    endcase

    // With no wait phase the response is formed on the accept edge from live inputs.
    if (state_r == S_IDLE) begin
      rd_idx_s  = req_idx_s;
      rd_size_s = req_size;
      rd_lane_s = req_addr[1:0];
      rd_uns_s  = req_unsigned;
      rd_we_s   = req_we;
      rd_err_s  = req_err_s;
    end else begin
      rd_idx_s  = idx_r;
      rd_size_s = size_r;
      rd_lane_s = lane_r;
      rd_uns_s  = uns_r;
      rd_we_s   = we_r;
      rd_err_s  = err_r;
    end

    rd_word_s = mem[rd_idx_s];
    if (rd_we_s || rd_err_s) begin
      rsp_word_s = 32'h0000_0000;
    end else begin
      rsp_word_s = load_format(rd_word_s, rd_size_s, rd_lane_s, rd_uns_s);
    end
  end

  // Lane-enabled memory write on the accept edge; contents are never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we_s && be_s[k]) begin
        mem[req_idx_s][8*k +: 8] <= wlane_s[8*k +: 8];
      end
    end
  end

  // Access sequencing, request capture and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= 4'd0;
      we_r      <= 1'b0;
      size_r    <= 2'b00;
      lane_r    <= 2'b00;
      uns_r     <= 1'b0;
      err_r     <= 1'b0;
      idx_r     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0000_0000;
          rsp_err   <= 1'b0;
          if (accept_s) begin
            we_r      <= req_we;
            size_r    <= req_size;
            lane_r    <= req_addr[1:0];
            uns_r     <= req_unsigned;
            err_r     <= req_err_s;
            idx_r     <= req_idx_s;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_r   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rsp_word_s;
              rsp_err   <= req_err_s;
            end else begin
              state_r <= S_WAIT;
              cnt_r   <= CNT_INIT;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r   <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_word_s;
            rsp_err   <= err_r;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_RESP: begin
          state_r   <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0000_0000;
          rsp_err   <= 1'b0;
        end
        default: begin
          state_r   <= S_IDLE;
          cnt_r     <= 4'd0;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0000_0000;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_mc.sv
// Self-checking bench for dm_mc: one instance per wait setting (1, 0, 3),
// a byte-addressed reference memory and randomized traffic on the main instance.
module tb_dm_mc;

  logic        clk;
  logic        rst;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_wdata;

  logic        valid1, valid0, valid3;
  logic        d1_ready, d0_ready, d3_ready;
  logic        d1_rv, d0_rv, d3_rv;
  logic [31:0] d1_rd, d0_rd, d3_rd;
  logic        d1_err, d0_err, d3_err;

  int checks = 0;
  int fails  = 0;

  logic [7:0] mref [0:511];

  dm_mc #(.ADDR_W(9), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(d1_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_uns), .req_wdata(req_wdata),
    .rsp_valid(d1_rv), .rsp_rdata(d1_rd), .rsp_err(d1_err));

  dm_mc #(.ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(valid0), .req_ready(d0_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_uns), .req_wdata(req_wdata),
    .rsp_valid(d0_rv), .rsp_rdata(d0_rd), .rsp_err(d0_err));

  dm_mc #(.ADDR_W(9), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(valid3), .req_ready(d3_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_uns), .req_wdata(req_wdata),
    .rsp_valid(d3_rv), .rsp_rdata(d3_rd), .rsp_err(d3_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rules: an access must be naturally aligned to its byte count.
  function automatic logic model_err(input logic [1:0] s, input logic [8:0] a);
    int nb;
    if (s == 2'd3) return 1'b1;
    nb = 1 << s;
    return (int'(a) % nb) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [8:0] a, input logic [1:0] s, input logic u);
    int nb;
    logic [31:0] v;
    if (model_err(s, a)) return 32'h0;
    nb = 1 << s;
    v = 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(mref[int'(a) + i]) << (8 * i));
    if (nb < 4 && !u && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic model_store(input logic [8:0] a, input logic [1:0] s, input logic [31:0] d);
    int nb;
    nb = 1 << s;
    for (int i = 0; i < nb; i++) mref[int'(a) + i] = 8'(d >> (8 * i));
  endtask

  // One transaction on the WAIT_CYCLES=1 instance; lat counts clocks from accept to response.
  task automatic txn1(input logic we, input logic [8:0] a, input logic [1:0] s, input logic u,
                      input logic [31:0] d, output logic [31:0] rdata, output logic err,
                      output int lat, output logic [2:0] tail);
    int n;
    rdata = 32'h0; err = 1'b0; lat = -1; tail = 3'b111;
    @(negedge clk);
    req_we = we; req_addr = a; req_size = s; req_uns = u; req_wdata = d; valid1 = 1'b1;
    n = 0;
    while (d1_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (d1_ready !== 1'b1) begin
      valid1 = 1'b0;
      return;
    end
    @(posedge clk);
    #1 valid1 = 1'b0;
    if (we && !model_err(s, a)) model_store(a, s, d);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (d1_rv === 1'b1) begin
        lat = i; rdata = d1_rd; err = d1_err;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      tail = {d1_rv, d1_err, |d1_rd};
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid1 = 1'b1; valid0 = 1'b1; valid3 = 1'b1;
    req_we = 1'b0; req_addr = 9'h000; req_size = 2'd2; req_uns = 1'b0; req_wdata = 32'h0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({d1_ready, d0_ready, d3_ready} !== 3'b000) begin
        fails++; $display("FAIL reset_ready: got %b expected 000", {d1_ready, d0_ready, d3_ready});
      end
      checks++;
      if ({d1_rv, d0_rv, d3_rv, d1_err} !== 4'b0000 || d1_rd !== 32'h0) begin
        fails++; $display("FAIL reset_outputs: rv=%b err=%b rdata=%h expected 0", {d1_rv, d0_rv, d3_rv}, d1_err, d1_rd);
      end
    end
    valid1 = 1'b0; valid0 = 1'b0; valid3 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({d1_ready, d0_ready, d3_ready} !== 3'b111) begin
      fails++; $display("FAIL reset_release_ready: got %b expected 111", {d1_ready, d0_ready, d3_ready});
    end
  endtask

  task automatic test_word_roundtrip;
    logic [31:0] rd; logic er; int lat; logic [2:0] tl;
    txn1(1'b1, 9'h010, 2'd2, 1'b0, 32'h8765_4321, rd, er, lat, tl);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat != 2) begin
      fails++; $display("FAIL word_store: rdata=%h err=%b lat=%0d expected 0/0/2", rd, er, lat);
    end
    txn1(1'b0, 9'h010, 2'd2, 1'b0, 32'h0, rd, er, lat, tl);
    checks++;
    if (rd !== 32'h8765_4321 || er !== 1'b0) begin
      fails++; $display("FAIL word_load: rdata=%h err=%b expected 87654321/0", rd, er);
    end
    checks++;
    if (lat != 2) begin
      fails++; $display("FAIL word_load_latency: got %0d expected 2", lat);
    end
    checks++;
    if (tl !== 3'b000) begin
      fails++; $display("FAIL rsp_return_zero: got %b expected 000", tl);
    end
  endtask

  task automatic test_subword_loads;
    logic [31:0] rd; logic er; int lat; logic [2:0] tl;
    logic [8:0]  a_t [4] = '{9'h013, 9'h013, 9'h012, 9'h010};
    logic [1:0]  s_t [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        u_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] e_t [4] = '{32'hFFFF_FF87, 32'h0000_0087, 32'hFFFF_8765, 32'h0000_4321};
    for (int i = 0; i < 4; i++) begin
      txn1(1'b0, a_t[i], s_t[i], u_t[i], 32'h0, rd, er, lat, tl);
      checks++;
      if (rd !== e_t[i] || er !== 1'b0) begin
        fails++; $display("FAIL subword_load_%0d: rdata=%h err=%b expected %h/0", i, rd, er, e_t[i]);
      end
    end
  endtask

  task automatic test_lane_stores;
    logic [31:0] rd; logic er; int lat; logic [2:0] tl;
    txn1(1'b1, 9'h011, 2'd0, 1'b0, 32'hFFFF_FFAA, rd, er, lat, tl);
    txn1(1'b1, 9'h012, 2'd1, 1'b0, 32'hFFFF_1234, rd, er, lat, tl);
    txn1(1'b0, 9'h010, 2'd2, 1'b0, 32'h0, rd, er, lat, tl);
    checks++;
    if (rd !== 32'h1234_AA21 || er !== 1'b0) begin
      fails++; $display("FAIL lane_stores: rdata=%h err=%b expected 1234aa21/0", rd, er);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat; logic [2:0] tl;
    txn1(1'b0, 9'h011, 2'd1, 1'b0, 32'h0, rd, er, lat, tl);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      fails++; $display("FAIL err_half_misaligned: rdata=%h err=%b expected 0/1", rd, er);
    end
    txn1(1'b1, 9'h012, 2'd2, 1'b0, 32'hFFFF_FFFF, rd, er, lat, tl);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      fails++; $display("FAIL err_word_store: rdata=%h err=%b expected 0/1", rd, er);
    end
    txn1(1'b0, 9'h010, 2'd2, 1'b0, 32'h0, rd, er, lat, tl);
    checks++;
    if (rd !== 32'h1234_AA21 || er !== 1'b0) begin
      fails++; $display("FAIL err_store_no_write: rdata=%h err=%b expected 1234aa21/0", rd, er);
    end
    txn1(1'b0, 9'h010, 2'd3, 1'b0, 32'h0, rd, er, lat, tl);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      fails++; $display("FAIL err_size11: rdata=%h err=%b expected 0/1", rd, er);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd; logic er; int lat; logic [2:0] tl;
    logic we_v, u_v; logic [8:0] a_v; logic [1:0] s_v; logic [31:0] d_v, exp_v; logic exp_e;
    for (int w = 0; w < 128; w++) begin
      txn1(1'b1, 9'(w * 4), 2'd2, 1'b0, $urandom, rd, er, lat, tl);
    end
    for (int i = 0; i < 120; i++) begin
      we_v = 1'($urandom_range(0, 1));
      u_v  = 1'($urandom_range(0, 1));
      a_v  = 9'($urandom_range(0, 511));
      s_v  = 2'($urandom_range(0, 3));
      d_v  = $urandom;
      exp_e = model_err(s_v, a_v);
      exp_v = we_v ? 32'h0 : model_load(a_v, s_v, u_v);
      txn1(we_v, a_v, s_v, u_v, d_v, rd, er, lat, tl);
      checks++;
      if (rd !== exp_v || er !== exp_e) begin
        fails++; $display("FAIL random_%0d we=%b a=%h s=%0d u=%b: rdata=%h err=%b expected %h/%b",
                          i, we_v, a_v, s_v, u_v, rd, er, exp_v, exp_e);
      end
      checks++;
      if (lat != 2) begin
        fails++; $display("FAIL random_latency_%0d: got %0d expected 2", i, lat);
      end
    end
  endtask

  // Hold valid high on the w-wait instance and check accept spacing and response timing.
  task automatic test_back_to_back(input int w);
    int acc[$]; int rsp[$]; int ncyc; int exp_acc; int exp_rsp;
    logic rdy, rv, er; logic [31:0] rd;
    ncyc = (w == 0) ? 16 : 30;
    @(negedge clk);
    req_we = 1'b1; req_addr = 9'h040; req_size = 2'd2; req_uns = 1'b0; req_wdata = $urandom;
    if (w == 0) valid0 = 1'b1; else valid3 = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      if (w == 0) begin rdy = d0_ready; rv = d0_rv; rd = d0_rd; er = d0_err; end
      else begin rdy = d3_ready; rv = d3_rv; rd = d3_rd; er = d3_err; end
      if (rdy === 1'b1) acc.push_back(n);
      if (rv === 1'b1) begin
        rsp.push_back(n);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
          fails++; $display("FAIL b2b_w%0d_store_rsp: rdata=%h err=%b expected 0/0", w, rd, er);
        end
      end
      checks++;
      if (rdy === 1'b1 && rv === 1'b1) begin
        fails++; $display("FAIL b2b_w%0d_ready_in_resp: cycle %0d ready=1 expected 0", w, n);
      end
      @(negedge clk);
    end
    valid0 = 1'b0; valid3 = 1'b0;
    exp_acc = (ncyc + w + 1) / (w + 2);
    exp_rsp = 0;
    for (int i = 0; i < exp_acc; i++) if (i * (w + 2) + w + 1 < ncyc) exp_rsp++;
    checks++;
    if (acc.size() != exp_acc || rsp.size() != exp_rsp) begin
      fails++; $display("FAIL b2b_w%0d_counts: accepts=%0d rsps=%0d expected %0d/%0d",
                        w, acc.size(), rsp.size(), exp_acc, exp_rsp);
    end
    for (int i = 0; i < acc.size(); i++) begin
      checks++;
      if (acc[i] != i * (w + 2)) begin
        fails++; $display("FAIL b2b_w%0d_accept_%0d: cycle %0d expected %0d", w, i, acc[i], i * (w + 2));
      end
    end
    for (int i = 0; i < rsp.size() && i < acc.size(); i++) begin
      checks++;
      if (rsp[i] != acc[i] + w + 1) begin
        fails++; $display("FAIL b2b_w%0d_rsp_%0d: cycle %0d expected %0d", w, i, rsp[i], acc[i] + w + 1);
      end
    end
    repeat (w + 3) @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd; logic er; int lat; logic [2:0] tl;
    @(negedge clk);
    req_we = 1'b1; req_addr = 9'h020; req_size = 2'd2; req_uns = 1'b0; req_wdata = 32'h5555_5555;
    valid1 = 1'b1;
    checks++;
    if (d1_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset_ready_before: got %b expected 1", d1_ready);
    end
    @(posedge clk);
    #1 valid1 = 1'b0;
    model_store(9'h020, 2'd2, 32'h5555_5555);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({d1_ready, d1_rv, d1_err} !== 3'b000 || d1_rd !== 32'h0) begin
        fails++; $display("FAIL mid_reset_outputs: ready=%b rv=%b err=%b rdata=%h expected all 0",
                          d1_ready, d1_rv, d1_err, d1_rd);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (d1_ready !== 1'b1) begin
          fails++; $display("FAIL mid_reset_ready_after: got %b expected 1", d1_ready);
        end
      end
      checks++;
      if (d1_rv !== 1'b0) begin
        fails++; $display("FAIL mid_reset_no_rsp: rsp_valid=%b expected 0", d1_rv);
      end
    end
    txn1(1'b0, 9'h020, 2'd2, 1'b0, 32'h0, rd, er, lat, tl);
    checks++;
    if (rd !== 32'h5555_5555 || er !== 1'b0 || lat != 2) begin
      fails++; $display("FAIL mid_reset_store_kept: rdata=%h err=%b lat=%0d expected 55555555/0/2", rd, er, lat);
    end
  endtask

  initial begin
    rst = 1'b1; valid1 = 1'b0; valid0 = 1'b0; valid3 = 1'b0;
    req_we = 1'b0; req_addr = 9'h000; req_size = 2'd0; req_uns = 1'b0; req_wdata = 32'h0;
    test_reset;
    test_word_roundtrip;
    test_subword_loads;
    test_lane_stores;
    test_errors;
    test_random;
    test_back_to_back(0);
    test_back_to_back(3);
    test_reset_mid_access;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dm_mc.md
# dm_mc

Multi-cycle data memory for the CPU load/store path: one 32-bit word-organised RAM with byte, halfword and word stores through lane enables, and sign- or zero-extended sub-word loads. It replaces the combinational-read data memory with a request/response handshake. Latency is set by a parameter, so the pipeline can model a slower memory and stall on `req_ready`. Misaligned or illegal accesses are detected and reported rather than printed.

## Interface
- `ADDR_W`, default 9: byte-address width. Depth is 2^(ADDR_W-2) words; the default gives 128 words.
- `WAIT_CYCLES`, default 1, legal range 0..15: extra cycles between accept and response.
- `clk`  in  1  rising-edge clock; the block has one clock.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE and not in reset.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  byte address.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load result; 0 for stores and for errors.
- `rsp_err`  out  1  access was misaligned or illegal; valid with `rsp_valid`.

## Operation
- **Accept:** a request is accepted on an edge where `req_valid & req_ready`. `req_*` are captured in holding registers. While busy, requests are ignored and not queued. At most one access is outstanding.
- **Word index and lanes:** word index = `req_addr[ADDR_W-1:2]`. Lanes are little-endian; lane k holds bits [8k+7:8k], with k = `req_addr[1:0]`.
- **Error check:** an access is in error when
  - `req_size` = 11, or
  - `req_size` = 01 and `req_addr[0]` = 1, or
  - `req_size` = 10 and `req_addr[1:0]` != 0.
  
  An erroring access never writes memory. Its response has `rsp_err`=1 and `rsp_rdata`=0.
- **Store:** memory is written on the accept edge.
  - Byte: lane k receives `wdata[7:0]`.
  - Half: lanes k and k+1 receive `wdata[15:0]`.
  - Word: all lanes are written.
  - Other lanes are unchanged.
  - The response has `rsp_rdata`=0 and `rsp_err`=0.
- **Load:** the word is read from the captured index on the edge entering RESP, so it reflects every store accepted earlier.
  - Byte: selected lane, extended from bit 7.
  - Half: lanes k+1..k, extended from bit 15.
  - Word: returned unchanged.
- **FSM:** states IDLE, WAIT, RESP.
  - IDLE→WAIT on accept when `WAIT_CYCLES`>0, loading the counter with `WAIT_CYCLES`-1.
  - IDLE→RESP on accept when `WAIT_CYCLES`=0.
  - WAIT decrements the counter and goes to RESP when the counter is 0.
  - RESP asserts `rsp_valid` for exactly one cycle, then goes to IDLE.
- **No response backpressure:** the requester must take the response in the cycle `rsp_valid` is high.
- **Memory contents** are not reset and are X until written.

## Timing
- **Reset values:** state=IDLE, counter=0, `req_ready`=0 during reset, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. `req_ready`=1 from the first cycle after `rst` deasserts.
- **Latency:** `rsp_valid` is high in the cycle WAIT_CYCLES+1 clocks after the accept edge.
- **Throughput:** the next accept is possible WAIT_CYCLES+2 clocks after the previous one, because `req_ready` is low in WAIT and RESP.
- **Response outputs:** `rsp_rdata` and `rsp_err` are registered, held stable while `rsp_valid` is high, and return to 0 in the cycle after.
- **Reset mid-access:** the pending response is discarded and no `rsp_valid` is produced. A store accepted before reset remains written.
- **Simultaneous reset and request:** `rst` has priority and the request is not accepted. This holds whether `rst` and `req_valid` are high on the same edge or `rst` is high throughout.

## Test plan
- **Word store/load round trip:** store word 0x8765_4321 at 0x010, then load word at 0x010 → `rsp_valid` 2 cycles after accept with `WAIT_CYCLES`=1, `rdata`=0x8765_4321, `err`=0.
- **Sub-word loads on the same word:** signed byte at 0x013 → 0xFFFF_FF87; unsigned byte at 0x013 → 0x0000_0087; signed half at 0x012 → 0xFFFF_8765; unsigned half at 0x010 → 0x0000_4321.
- **Lane-enabled stores:** store byte 0xAA at 0x011, then store half 0x1234 at 0x012, then load word at 0x010 → 0x1234_AA21.
- **Errors:**
  - Half load at 0x011 → `err`=1, `rdata`=0.
  - Word store at 0x012 with data 0xFFFF_FFFF → `err`=1; a following word load at 0x010 is unchanged.
  - `req_size`=11 → `err`=1.
- **Handshake and latency:** hold `req_valid` high continuously with `WAIT_CYCLES`=0 and then 3 → accepts spaced 2 and 5 cycles apart, `req_ready` low during WAIT and RESP, one `rsp_valid` pulse per accept.
- **Reset:** assert `rst` in WAIT after a store of 0x5555_5555 at 0x020 → no `rsp_valid`, all outputs 0, `req_ready` high the cycle after release; a subsequent load at 0x020 returns 0x5555_5555.
